// File: rtl/enigma_multi_rotor.sv
// rtl/enigma_multi_rotor.sv - multi-rotor Caesar/Enigma-style letter shifter
// Optional historical double-step: define ENIGMA_DOUBLE_STEP_EN.
module enigma_multi_rotor #(
  parameter int NUM_ROTORS = 3,
  parameter int NOTCH_POS  = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    encrypt,
  input  logic [7:0]              char_in,
  input  logic                    char_valid,
  output logic                    char_ready,
  output logic [7:0]              letter_out,
  output logic                    out_valid,
  input  logic                    load_init,
  input  logic [5*NUM_ROTORS-1:0] rotor_init,
  output logic [5*NUM_ROTORS-1:0] rotor_pos
);

  typedef enum logic [1:0] {IDLE, STEP, SHIFT, DONE} state_t;

  localparam logic [4:0] NOTCH = 5'(NOTCH_POS);

  state_t                         state, state_next;
  logic [NUM_ROTORS-1:0][4:0]     rotor;
  logic [NUM_ROTORS-1:0][4:0]     rotor_step;
  logic [NUM_ROTORS-1:0]          at_notch;
  logic [NUM_ROTORS-1:0]          advance;
  logic [7:0]                     char_q;
  logic                           enc_q;
  logic                           accept;
  logic                           is_upper, is_lower, is_letter;
  logic [6:0]                     pos_sum;
  logic [4:0]                     shift_amt;
  logic [7:0]                     base;
  logic [4:0]                     idx;
  logic [5:0]                     shifted_raw;
  logic [5:0]                     shifted;
  logic [7:0]                     cipher;

  assign rotor_pos = rotor;
  assign accept    = char_valid & char_ready;
  assign out_valid = (state == DONE);

  always_comb begin
    state_next = state;
    char_ready = 1'b0;
    case (state)
      IDLE: begin
        char_ready = ~load_init;
        if (char_valid && !load_init) state_next = STEP;
      end
      STEP:    state_next = SHIFT;
      SHIFT:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Advance flags are taken from the pre-step positions of all rotors.
  always_comb begin
    for (int k = 0; k < NUM_ROTORS; k++) at_notch[k] = (rotor[k] == NOTCH);
    advance    = '0;
    advance[0] = 1'b1;
    for (int k = 1; k < NUM_ROTORS; k++) begin
`ifdef ENIGMA_DOUBLE_STEP_EN
      advance[k] = at_notch[k-1] | ((k <= NUM_ROTORS - 2) & at_notch[k]);
`else
      advance[k] = advance[k-1] & at_notch[k-1];
`endif
    end
    for (int k = 0; k < NUM_ROTORS; k++) begin
      if (!advance[k])             rotor_step[k] = rotor[k];
      else if (rotor[k] == 5'd25)  rotor_step[k] = 5'd0;
      else                         rotor_step[k] = rotor[k] + 5'd1;
    end
  end

  assign is_upper  = (char_q >= 8'h41) && (char_q <= 8'h5A);
  assign is_lower  = (char_q >= 8'h61) && (char_q <= 8'h7A);
  assign is_letter = is_upper | is_lower;

  // Shift datapath works on the already-stepped rotors held in SHIFT.
  always_comb begin
    pos_sum = '0;
    for (int k = 0; k < NUM_ROTORS; k++) pos_sum = pos_sum + 7'(rotor[k]);
    shift_amt = 5'(pos_sum % 7'd26);
    base      = is_upper ? 8'h41 : 8'h61;
    idx       = 5'(char_q - base);
    if (enc_q) shifted_raw = {1'b0, idx} + {1'b0, shift_amt};
    else       shifted_raw = {1'b0, idx} + 6'd26 - {1'b0, shift_amt};
    shifted = (shifted_raw >= 6'd26) ? shifted_raw - 6'd26 : shifted_raw;
    cipher  = base + 8'(shifted);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rotor      <= '0;
      letter_out <= 8'h00;
      char_q     <= 8'h00;
      enc_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        char_q <= char_in;
        enc_q  <= encrypt;
      end
      // Out-of-range init fields fold back into 0..25.
      if (state == IDLE && load_init) begin
        for (int k = 0; k < NUM_ROTORS; k++) begin
          if (rotor_init[5*k +: 5] >= 5'd26) rotor[k] <= rotor_init[5*k +: 5] - 5'd26;
          else                               rotor[k] <= rotor_init[5*k +: 5];
        end
      end
      if (state == STEP && is_letter) rotor <= rotor_step;
      if (state == SHIFT) letter_out <= is_letter ? cipher : char_q;
    end
  end

endmodule

// File: tb/tb_enigma_multi_rotor.sv
// tb/tb_enigma_multi_rotor.sv - self-checking bench for enigma_multi_rotor
module tb_enigma_multi_rotor;

  logic        clk = 1'b0;
  logic        reset;
  logic        encrypt;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  letter_out;
  logic        out_valid;
  logic        load_init;
  logic [14:0] rotor_init;
  logic [14:0] rotor_pos;

  int checks   = 0;
  int failures = 0;
  int mrot[3];

  enigma_multi_rotor #(.NUM_ROTORS(3), .NOTCH_POS(25)) dut (
    .clk(clk), .reset(reset), .encrypt(encrypt), .char_in(char_in),
    .char_valid(char_valid), .char_ready(char_ready), .letter_out(letter_out),
    .out_valid(out_valid), .load_init(load_init), .rotor_init(rotor_init),
    .rotor_pos(rotor_pos)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] model_pos();
    return {5'(mrot[2]), 5'(mrot[1]), 5'(mrot[0])};
  endfunction

  function automatic bit model_is_letter(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  // Odometer with notch 25 is just a base-26 counter over the rotor triple.
  function automatic void model_step();
`ifdef ENIGMA_DOUBLE_STEP_EN
    bit a1, a2;
    a1 = (mrot[0] == 25) || (mrot[1] == 25);
    a2 = (mrot[1] == 25);
    mrot[0] = (mrot[0] + 1) % 26;
    if (a1) mrot[1] = (mrot[1] + 1) % 26;
    if (a2) mrot[2] = (mrot[2] + 1) % 26;
`else
    int v;
    v = mrot[0] + 26 * mrot[1] + 676 * mrot[2];
    v = (v + 1) % 17576;
    mrot[0] = v % 26;
    mrot[1] = (v / 26) % 26;
    mrot[2] = v / 676;
`endif
  endfunction

  function automatic logic [7:0] model_cipher(input logic [7:0] c, input logic enc);
    int s, b, o;
    if (!model_is_letter(c)) return c;
    s = (mrot[0] + mrot[1] + mrot[2]) % 26;
    b = (c <= "Z") ? 65 : 97;
    if (enc) o = b + ((int'(c) - b + s) % 26);
    else     o = b + ((int'(c) - b - s + 26) % 26);
    return 8'(o);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mrot = '{0, 0, 0};
  endtask

  task automatic do_load(input int v0, input int v1, input int v2);
    @(negedge clk);
    load_init  = 1'b1;
    rotor_init = {5'(v2), 5'(v1), 5'(v0)};
    @(negedge clk);
    load_init  = 1'b0;
    mrot[0] = (v0 >= 26) ? v0 - 26 : v0;
    mrot[1] = (v1 >= 26) ? v1 - 26 : v1;
    mrot[2] = (v2 >= 26) ? v2 - 26 : v2;
  endtask

  // Stimulus only: offers a character, scrambles inputs after accept, reports timing.
  task automatic run_char(input logic [7:0] c, input logic enc, output logic [7:0] out,
                          output int lat, output logic rdy_before, output logic ov_after,
                          output logic rdy_after);
    @(negedge clk);
    char_in = c; encrypt = enc; char_valid = 1'b1;
    #1 rdy_before = char_ready;
    lat = -1; out = 8'hxx;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        char_valid = 1'b0; char_in = c ^ 8'h15; encrypt = ~enc;
      end
      if (out_valid) begin
        lat = n; out = letter_out;
        break;
      end
    end
    @(negedge clk);
    ov_after = out_valid; rdy_after = char_ready;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++;
    if (letter_out !== 8'h00) begin failures++; $display("FAIL reset_letter got=%h exp=00", letter_out); end
    checks++;
    if (rotor_pos !== 15'd0) begin failures++; $display("FAIL reset_rotors got=%h exp=0", rotor_pos); end
    checks++;
    reset = 1'b0;
    #1;
    if (char_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", char_ready); end
    checks++;
    mrot = '{0, 0, 0};
  endtask

  task automatic test_vectors();
    logic [7:0] out; int lat; logic rb, ova, rda;
    logic [7:0] exp_c; logic [14:0] exp_p;
    // 'A' from reset
    do_reset();
    run_char("A", 1'b1, out, lat, rb, ova, rda);
    if (out !== "B") begin failures++; $display("FAIL vec_A_out got=%h exp=%h", out, "B"); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL vec_A_latency got=%0d exp=3", lat); end
    checks++;
    if (rotor_pos !== {5'd0, 5'd0, 5'd1}) begin failures++; $display("FAIL vec_A_rotors got=%h exp=%h", rotor_pos, {5'd0, 5'd0, 5'd1}); end
    checks++;
    if (rb !== 1'b1 || ova !== 1'b0 || rda !== 1'b1) begin failures++; $display("FAIL vec_A_handshake got=%0b%0b%0b exp=101", rb, ova, rda); end
    checks++;
    // full carry 25,25,0
    do_load(25, 25, 0);
    run_char("a", 1'b1, out, lat, rb, ova, rda);
    if (out !== "b") begin failures++; $display("FAIL vec_carry_out got=%h exp=%h", out, "b"); end
    checks++;
    if (rotor_pos !== {5'd1, 5'd0, 5'd0}) begin failures++; $display("FAIL vec_carry_rotors got=%h exp=%h", rotor_pos, {5'd1, 5'd0, 5'd0}); end
    checks++;
    // middle rotor parked on notch
    do_load(3, 25, 0);
    run_char("A", 1'b1, out, lat, rb, ova, rda);
`ifdef ENIGMA_DOUBLE_STEP_EN
    exp_c = "F"; exp_p = {5'd1, 5'd0, 5'd4};
`else
    exp_c = "D"; exp_p = {5'd0, 5'd25, 5'd4};
`endif
    if (out !== exp_c) begin failures++; $display("FAIL vec_notch_out got=%h exp=%h", out, exp_c); end
    checks++;
    if (rotor_pos !== exp_p) begin failures++; $display("FAIL vec_notch_rotors got=%h exp=%h", rotor_pos, exp_p); end
    checks++;
    // decrypt and wraparound
    do_reset();
    run_char("B", 1'b0, out, lat, rb, ova, rda);
    if (out !== "A" || rotor_pos !== {5'd0, 5'd0, 5'd1}) begin failures++; $display("FAIL vec_decrypt got=%h/%h exp=41/0001", out, rotor_pos); end
    checks++;
    do_load(0, 0, 0);
    run_char("Z", 1'b1, out, lat, rb, ova, rda);
    if (out !== "A") begin failures++; $display("FAIL vec_wrap_out got=%h exp=41", out); end
    checks++;
    mrot = '{1, 0, 0};
    // non-letter passthrough
    exp_p = rotor_pos;
    run_char("5", 1'b1, out, lat, rb, ova, rda);
    if (out !== "5" || rotor_pos !== exp_p || lat !== 3) begin failures++; $display("FAIL vec_nonletter got=%h/%h/%0d exp=35/%h/3", out, rotor_pos, lat, exp_p); end
    checks++;
    // load and valid together: load wins
    @(negedge clk);
    load_init = 1'b1; rotor_init = {5'd30, 5'd7, 5'd12}; char_valid = 1'b1; char_in = "Q"; encrypt = 1'b1;
    #1;
    if (char_ready !== 1'b0) begin failures++; $display("FAIL vec_load_ready got=%0b exp=0", char_ready); end
    checks++;
    @(negedge clk);
    load_init = 1'b0; char_valid = 1'b0;
    mrot = '{12, 7, 4};
    begin
      bit saw = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (out_valid) saw = 1;
      end
      if (saw) begin failures++; $display("FAIL vec_load_no_out got=1 exp=0"); end
      checks++;
    end
    if (rotor_pos !== model_pos()) begin failures++; $display("FAIL vec_load_rotors got=%h exp=%h", rotor_pos, model_pos()); end
    checks++;
  endtask

  task automatic test_random();
    logic [7:0] out, c, exp_c; int lat; logic rb, ova, rda, enc;
    int bad = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0)
        do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0, 3:    c = 8'($urandom_range(65, 90));
        1:       c = 8'($urandom_range(97, 122));
        default: c = 8'($urandom_range(0, 255));
      endcase
      enc = 1'($urandom_range(0, 1));
      run_char(c, enc, out, lat, rb, ova, rda);
      if (model_is_letter(c)) model_step();
      exp_c = model_cipher(c, enc);
      checks++;
      if (out !== exp_c || lat !== 3 || rotor_pos !== model_pos() || letter_out !== exp_c
          || rb !== 1'b1 || ova !== 1'b0 || rda !== 1'b1) begin
        failures++;
        if (bad < 5) $display("FAIL rand_%0d char=%h enc=%0b got=%h lat=%0d pos=%h exp=%h pos=%h", i, c, enc, out, lat, rotor_pos, exp_c, model_pos());
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [7:0] exp_c;
    do_load(22, 25, 3);
    @(negedge clk);
    char_in = "C"; encrypt = 1'b1; char_valid = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (i == 1) begin load_init = 1'b1; rotor_init = {5'd7, 5'd7, 5'd7}; end
      if (i == 2) load_init = 1'b0;
      if (i == 16) char_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) model_step();
    exp_c = model_cipher("C", 1'b1);
    if (pulses !== 4) begin failures++; $display("FAIL b2b_pulses got=%0d exp=4", pulses); end
    checks++;
    if (rotor_pos !== model_pos()) begin failures++; $display("FAIL b2b_rotors got=%h exp=%h", rotor_pos, model_pos()); end
    checks++;
    if (letter_out !== exp_c) begin failures++; $display("FAIL b2b_letter got=%h exp=%h", letter_out, exp_c); end
    checks++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] out; int lat; logic rb, ova, rda;
    bit saw = 0;
    do_load(4, 9, 1);
    run_char("m", 1'b1, out, lat, rb, ova, rda);
    @(negedge clk);
    char_in = "K"; encrypt = 1'b1; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (out_valid !== 1'b0 || rotor_pos !== 15'd0 || letter_out !== 8'h00) begin
      failures++; $display("FAIL abort_state got=%0b/%h/%h exp=0/0000/00", out_valid, rotor_pos, letter_out);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    reset = 1'b0;
    #1;
    if (char_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%0b exp=1", char_ready); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    if (saw) begin failures++; $display("FAIL abort_no_out got=1 exp=0"); end
    checks++;
    mrot = '{0, 0, 0};
  endtask

  initial begin
    reset = 1'b1; encrypt = 1'b0; char_in = 8'h00; char_valid = 1'b0;
    load_init = 1'b0; rotor_init = '0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enigma_multi_rotor.md
ENIGMA_MULTI_ROTOR -- requirements
Module: enigma_multi_rotor

Interface
REQ-001 Parameter NUM_ROTORS, default 3, number of cascaded rotors; legal range 1..4.
REQ-002 Parameter NOTCH_POS, default 25, position (0..25) at which a rotor carries into its successor.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 encrypt  input  1  1 = positive shift (encrypt), 0 = negative shift (decrypt); sampled at character accept.
REQ-006 char_in  input  8  ASCII character; sampled at accept.
REQ-007 char_valid  input  1  character request.
REQ-008 char_ready  output  1  block can accept a character this cycle.
REQ-009 letter_out  output  8  ASCII result; held until the next result.
REQ-010 out_valid  output  1  one-cycle pulse marking a new letter_out.
REQ-011 load_init  input  1  load rotor_init into all rotors.
REQ-012 rotor_init  input  5*NUM_ROTORS  initial positions; rotor k in bits [5k+4:5k].
REQ-013 rotor_pos  output  5*NUM_ROTORS  current rotor positions, same packing.

Function
REQ-014 FSM states IDLE, STEP, SHIFT, DONE; IDLE->STEP on accept, STEP->SHIFT, SHIFT->DONE, DONE->IDLE unconditionally.
REQ-015 char_ready = 1 only in IDLE with load_init = 0; accept = char_valid & char_ready.
REQ-016 out_valid is high exactly during DONE; latency accept edge to out_valid = 3 cycles; next accept no earlier than the cycle after DONE.
REQ-017 Letter = char_in in 'A'..'Z' or 'a'..'z'; non-letters pass through unchanged to letter_out and cause no rotor step, still via full 3-cycle sequence.
REQ-018 In STEP (letters only) rotor 0 always advances by 1 modulo 26; rotor k>=1 advances iff every rotor 0..k-1 was at NOTCH_POS before the step (odometer).
REQ-019 Each rotor position is 0..25 at all times; advance from 25 yields 0.
REQ-020 In SHIFT, S = (sum of all post-step rotor positions) mod 26; encrypt: out = base + ((c - base + S) mod 26), decrypt: out = base + ((c - base - S + 26) mod 26), base = 'A' or 'a', case preserved.
REQ-021 load_init in IDLE loads every rotor from rotor_init in one cycle; field values 26..31 load as value-26.
REQ-022 load_init outside IDLE is ignored; load_init with char_valid in IDLE: load wins, character not accepted.
REQ-023 char_valid outside IDLE is ignored; encrypt and char_in changes after accept have no effect.

Reset
REQ-024 reset asserted forces immediately: state IDLE, all rotors 0, letter_out 8'h00, out_valid 0.
REQ-025 reset during STEP/SHIFT/DONE aborts the character with no out_valid pulse.
REQ-026 After reset deassertion char_ready is 1 in the first cycle (load_init = 0).

Configuration
REQ-027 Macro ENIGMA_DOUBLE_STEP_EN defined: rotor k (1<=k<=NUM_ROTORS-1) advances iff rotor k-1 was at NOTCH_POS, or (k<=NUM_ROTORS-2 and rotor k was at NOTCH_POS) (historical double step).
REQ-028 Macro not defined: pure odometer per REQ-018; for NUM_ROTORS<=2 both modes are identical.

Verification (NUM_ROTORS=3, NOTCH_POS=25)
REQ-029 Reset, encrypt=1, 'A' -> letter_out 'B' 3 cycles after accept, rotor_pos r0=1,r1=0,r2=0.
REQ-030 Load 25,25,0; encrypt 'a' -> rotors 0,0,1; letter_out 'b'.
REQ-031 Load 3,25,0; encrypt 'A' -> with ENIGMA_DOUBLE_STEP_EN rotors 4,0,1, out 'F'; without macro rotors 4,25,0, out 'D'.
REQ-032 Reset, decrypt 'B' -> rotors 1,0,0, out 'A'; then load 0,0,0, encrypt 'Z' -> out 'A'.
REQ-033 Encrypt '5' -> out '5', rotor_pos unchanged; load_init and char_valid same cycle -> load taken, no out_valid.
REQ-034 Reset asserted in SHIFT -> no out_valid, rotors 0, letter_out 8'h00, char_ready 1 after release.
